wb_host_master: RTL and testbench

Wishbone classic single-transfer master: the initiator side of the Wishbone slave bus exposed by the user project wrapper. It accepts one read or write command at a time on a valid/ready port, runs it as a single Wishbone cycle, and returns read data or an error on a valid/ready response port. A cycle counter aborts any transfer whose slave never acknowledges. It sits in the host/test harness or management-side logic that drives `wbs_*` on the project wrapper.

---
 rtl/wb_host_pkg.sv | 17 +
 rtl/wb_host_master.sv | 130 +++++++++++++
 tb/tb_wb_host_master.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone single-transfer host master.
package wb_host_pkg;

  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;

  // Data returned on the response port for writes and timed-out transfers.
  localparam logic [WB_DW-1:0] RSP_ERR_DAT = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_host_state_t;

endpackage

// File: rtl/wb_host_master.sv
// Wishbone classic master: one command in, one bus cycle, one response out,
// with a cycle counter that aborts transfers the slave never acknowledges.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [WB_AW-1:0]   cmd_adr_i,
  input  logic [WB_DW-1:0]   cmd_dat_i,
  input  logic [WB_SELW-1:0] cmd_sel_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WB_DW-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [WB_DW-1:0]   wbm_dat_i
);

  wb_host_state_t     state_q, state_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic [WB_DW-1:0]   dat_q, dat_d;
  logic [WB_SELW-1:0] sel_q, sel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WB_DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cnt_d   = '0;
        end
      end
      BUS: begin
        // Bus fields are cleared on exit so dat/we never linger outside a cycle.
        if (wbm_ack_i || (cnt_q == TW'(TIMEOUT - 1))) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          adr_d       = '0;
          dat_d       = '0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !wbm_ack_i;
          rsp_dat_d   = (wbm_ack_i && !we_q) ? wbm_dat_i : RSP_ERR_DAT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: driver tasks act as slave, a monitor
// scores responses against an expected-response queue.
module tb_wb_host_master;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic        ack = 1'b0;
  logic [31:0] dat_i = '0;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  wb_host_master #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response handshake pops one expected {err,dat}.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_dat", rsp_dat, e[31:0]);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
      end
    end
  end

  // Present a command and hold it until the DUT accepts it.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int t;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("cmd_accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Slave side: ack on stb cycle ack_at (0 = never), check bus fields and stb length.
  task automatic slave(input int ack_at, input logic [31:0] rdata, input int exp_len,
                       input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!stb) break;
      n++;
      check("bus_cyc", {31'd0, cyc}, 32'd1);
      check("bus_we", {31'd0, we}, {31'd0, w});
      check("bus_adr", adr, a);
      check("bus_sel", {28'd0, sel}, {28'd0, s});
      if (w) check("bus_dat", dat_o, d);
      if (n == ack_at) begin ack = 1'b1; dat_i = rdata; end
      else ack = 1'b0;
    end
    ack = 1'b0;
    check("stb_len", n, exp_len);
    check("rsp_valid_after_bus", {31'd0, rsp_valid}, 32'd1);
    check("idle_dat_o", dat_o, 32'd0);
    check("idle_we", {31'd0, we}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_rsp_dat"}, rsp_dat, 32'd0);
    check({tag, "_cyc_stb"}, {30'd0, cyc, stb}, 32'd0);
    check({tag, "_bus"}, adr | dat_o | {27'd0, we, sel}, 32'd0);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Zero-wait write
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
    slave(1, 32'hDEAD_BEEF, 1, 1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);

    // Read with 4 wait states
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    slave(5, 32'hCAFE_F00D, 5, 1'b0, 32'h3000_0010, 32'h0, 4'hF);

    // Timeout, no ack
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    slave(0, 32'h0, TO, 1'b0, 32'h3000_0020, 32'h0, 4'hF);

    // Ack on the last allowed cycle wins over timeout
    exp_q.push_back({1'b0, 32'h1234_5678});
    issue(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    slave(TO, 32'h1234_5678, TO, 1'b0, 32'h3000_0024, 32'h0, 4'hF);

    // Partial select write
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 32'h3000_0030, 32'h0BAD_F00D, 4'h6);
    slave(2, 32'hFFFF_FFFF, 2, 1'b1, 32'h3000_0030, 32'h0BAD_F00D, 4'h6);

    // Response backpressure with a pending command
    @(posedge clk); #1 rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h5555_AAAA});
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    slave(1, 32'h5555_AAAA, 1, 1'b0, 32'h3000_0040, 32'h0, 4'hF);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0050; cmd_dat = 32'h7777_0001; cmd_sel = 4'h3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_dat", rsp_dat, 32'h5555_AAAA);
      check("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("bp_no_cyc", {31'd0, cyc}, 32'd0);
    end
    exp_q.push_back({1'b0, 32'h0});
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_same_cycle", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("bp_ready_next_cycle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    slave(1, 32'h0, 1, 1'b1, 32'h3000_0050, 32'h7777_0001, 4'h3);

    // Reset during BUS on the 2nd wait cycle; no response may follow
    issue(1'b0, 32'h3000_0060, 32'h0, 4'hF);
    @(negedge clk); check("rst_bus_stb1", {31'd0, stb}, 32'd1);
    @(negedge clk); check("rst_bus_stb2", {31'd0, stb}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * TO; i++) begin
      @(negedge clk);
      if (rsp_valid || cyc) seen++;
    end
    check("no_rsp_after_reset", seen, 0);

    // Stray ack while idle
    ack = 1'b1; dat_i = 32'hFFFF_0000;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    check_reset_outputs("stray_ack");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
